// File: rtl/tap_counter_pkg.sv
// tap_counter_pkg
//   Shared types and constants for the tap_counter block.
//   mode_e  : terminal behaviour of the counter (free-run, modulo, one-shot).
//             The reserved encoding behaves like free-run.
//   state_e : two-state control FSM (counting / one-shot finished).
//   DIR_UP / DIR_DOWN : encodings of the dir input.
package tap_counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_MOD     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tap_counter_step.sv
// tap_counter_step
//   Combinational next-value unit for tap_counter. Given the current count and
//   the sampled controls it produces the value one count step would load.
//   Ports:
//     cnt      in  CNT_W  current counter value
//     dir      in  1      DIR_UP / DIR_DOWN
//     mode     in  mode_e terminal behaviour
//     limit    in  CNT_W  terminal value (modulo / one-shot)
//     cnt_next out CNT_W  counter value after the step
//     wrap_hit out 1      this step wraps (free-run / modulo only)
//     term_hit out 1      this step finishes a one-shot run
module tap_counter_step
  import tap_counter_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             dir,
  input  mode_e            mode,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt_next,
  output logic             wrap_hit,
  output logic             term_hit
);

  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_inc = cnt + ONE;
  assign cnt_dec = cnt - ONE;

  always_comb begin
    cnt_next = cnt;
    wrap_hit = 1'b0;
    term_hit = 1'b0;
    case (mode)
      MODE_MOD: begin
        if (dir == DIR_UP) begin
          // >= so that lowering limit below the current count still wraps.
          if (cnt >= limit) begin
            cnt_next = ZERO;
            wrap_hit = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          // Reload from limit at zero, or when limit was lowered below cnt.
          if ((cnt == ZERO) || (cnt > limit)) begin
            cnt_next = limit;
            wrap_hit = 1'b1;
          end else begin
            cnt_next = cnt_dec;
          end
        end
      end
      MODE_ONESHOT: begin
        if (dir == DIR_UP) begin
          if (cnt < limit) begin
            cnt_next = cnt_inc;
            term_hit = (cnt_inc == limit);
          end else begin
            // Already at/past the terminal: finish without moving.
            term_hit = 1'b1;
          end
        end else begin
          if (cnt != ZERO) begin
            cnt_next = cnt_dec;
            term_hit = (cnt_dec == ZERO);
          end else begin
            term_hit = 1'b1;
          end
        end
      end
      default: begin
        // Free-run and the reserved encoding: plain modular arithmetic.
        if (dir == DIR_UP) begin
          cnt_next = cnt_inc;
          wrap_hit = (cnt == ONES);
        end else begin
          cnt_next = cnt_dec;
          wrap_hit = (cnt == ZERO);
        end
      end
    endcase
  end

endmodule

// File: rtl/tap_counter.sv
// tap_counter
//   Programmable up/down counter with a bit-window output, used as a divided
//   timebase. Supports free-run, modulo and one-shot terminal modes, and emits
//   strobes when the tapped window moves (tick) or the counter wraps (wrap).
//   Ports:
//     clk      in  1      clock, rising edge
//     rst      in  1      asynchronous active-high reset
//     en       in  1      count enable (one step per enabled cycle)
//     clr      in  1      synchronous clear to 0 (beats load and en)
//     load     in  1      synchronous load of load_val (beats en)
//     load_val in  CNT_W  load value
//     dir      in  1      0 = up, 1 = down
//     mode     in  2      00 free-run, 01 modulo, 10 one-shot, 11 free-run
//     limit    in  CNT_W  terminal value for modulo / one-shot
//     val      out OUT_W  cnt[TAP_LSB +: OUT_W]
//     tick     out 1      val moved because of a count step (registered)
//     wrap     out 1      counter wrapped on this step (registered)
//     done     out 1      one-shot terminal reached (level)
module tap_counter
  import tap_counter_pkg::*;
#(
  parameter int CNT_W   = 61,
  parameter int OUT_W   = 32,
  parameter int TAP_LSB = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] limit,
  output logic [OUT_W-1:0] val,
  output logic             tick,
  output logic             wrap,
  output logic             done
);

  if (TAP_LSB + OUT_W > CNT_W) begin : g_bad_window
    $error("tap_counter: TAP_LSB + OUT_W must not exceed CNT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [CNT_W-1:0] step_next;
  logic             step_wrap;
  logic             step_term;

  tap_counter_step #(
    .CNT_W (CNT_W)
  ) u_step (
    .cnt      (cnt_q),
    .dir      (dir),
    .mode     (mode_e'(mode)),
    .limit    (limit),
    .cnt_next (step_next),
    .wrap_hit (step_wrap),
    .term_hit (step_term)
  );

  // Priority: clr > load > count step. In ST_DONE an enable does nothing,
  // so the count stays frozen until clr/load (or reset).
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      state_d = ST_COUNT;
    end else if (load) begin
      cnt_d   = load_val;
      state_d = ST_COUNT;
    end else if (en && (state_q == ST_COUNT)) begin
      cnt_d  = step_next;
      wrap_d = step_wrap;
      tick_d = (step_next[TAP_LSB +: OUT_W] != cnt_q[TAP_LSB +: OUT_W]);
      // term_hit is only ever raised in one-shot mode.
      if (step_term) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_COUNT;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign val  = cnt_q[TAP_LSB +: OUT_W];
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign done = (state_q == ST_DONE);

endmodule

// File: doc/tap_counter.md
# tap_counter

Parametrised free-running/programmable counter with a selectable output bit window. It provides the divided-down timebases used by display refresh, LED blink and delay logic. Compared with a plain free-running divider, it adds reset, enable, synchronous clear/load, up/down counting and three terminal modes. It also emits strobes when the tapped window advances, wraps or finishes.

## Interface
- `CNT_W`, 61: internal counter width.
- `OUT_W`, 32: width of `val`.
- `TAP_LSB`, 19: lowest counter bit presented on `val`. Constraint: `TAP_LSB + OUT_W <= CNT_W`, enforced by elaboration-time assertion.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable, one step per enabled cycle.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  CNT_W  load value.
- `dir`  in  1  0 = up, 1 = down.
- `mode`  in  2  00 = free-run, 01 = modulo, 10 = one-shot, 11 = treated as free-run.
- `limit`  in  CNT_W  terminal value for modulo and one-shot modes.
- `val`  out  OUT_W  `cnt[TAP_LSB +: OUT_W]`, taken straight off the counter register.
- `tick`  out  1  one-cycle pulse when `val` changed because of a count step.
- `wrap`  out  1  one-cycle pulse when the counter wrapped.
- `done`  out  1  level: one-shot terminal reached.

## Operation
- Per-edge priority: `rst` > `clr` > `load` > count step (`en`=1).
- `clr`: `cnt`=0, FSM goes to COUNT.
- `load`: `cnt`=`load_val`, FSM goes to COUNT. Both ignore `en`.
- FSM states:
  - COUNT: counting per `mode`/`dir`.
  - DONE: `cnt` frozen, `done`=1.
  - DONE is left only via `rst`, `clr` or `load`. Changes to `mode`, `dir` or `en` do not exit DONE.
- Free-run: modular 2^CNT_W arithmetic.
  - Up: all-ones → 0 raises `wrap`.
  - Down: 0 → all-ones raises `wrap`.
- Modulo, up:
  - If `cnt >= limit`, next = 0 and `wrap`. Otherwise next = `cnt+1`.
  - Using `>=` covers `limit` being lowered below `cnt`.
- Modulo, down:
  - If `cnt == 0` or `cnt > limit`, next = `limit` and `wrap`. Otherwise next = `cnt-1`.
  - `limit`=0: `cnt` stays 0 and `wrap` pulses every enabled cycle.
- One-shot, up:
  - Step while `cnt < limit`.
  - The step producing `cnt == limit` also enters DONE.
  - Enabled with `cnt >= limit`: enter DONE, `cnt` unchanged.
- One-shot, down:
  - Step while `cnt > 0`.
  - Reaching 0 enters DONE.
  - Enabled with `cnt == 0`: enter DONE, `cnt` unchanged.
  - `wrap` never asserts in one-shot mode.
- `tick` = count step taken AND next `val` ≠ current `val`. It never fires for `clr` or `load`.

## Timing
- Reset values: `cnt`=0, `val`=0, `tick`=0, `wrap`=0, `done`=0, FSM=COUNT. All apply asynchronously on `rst` assertion.
- `val` reflects `cnt` with zero added latency and updates on the same edge as the step.
- `tick`, `wrap` and `done` are registered. They assert on the same edge as the `cnt` value they describe.
  - Example: `wrap` is high in the cycle where `cnt` = 0 after an up-wrap.
- `tick` and `wrap` are high for exactly one cycle per event. Consecutive events give back-to-back pulses.
- `done` asserts on the edge `cnt` reaches the terminal value. It deasserts on the `clr`/`load` edge.
- Control inputs are sampled at the edge. A `mode`, `dir` or `limit` change affects the next step only.
- `en`=0 holds `cnt`; `tick` and `wrap` are 0 that cycle.

## Structure
- `tap_counter_pkg` holds:
  - `mode_e` (MODE_FREE, MODE_MOD, MODE_ONESHOT, MODE_RSVD).
  - `state_e` (ST_COUNT, ST_DONE).
  - Direction constants DIR_UP and DIR_DOWN.
- Sub-module `tap_counter_step`: combinational next-value unit. Inputs `cnt`, `dir`, `mode`, `limit`. Outputs next `cnt`, `wrap_hit`, `term_hit`.
- The top holds the counter register, FSM, priority mux and pulse registers.

## Test plan
All scenarios use `CNT_W`=8, `OUT_W`=4, `TAP_LSB`=2.
- Free-run up: load 0xFE, `en`=1 → `cnt` 0xFF (`val` 0xF, `tick` 0) → 0x00 (`val` 0x0, `tick`=1, `wrap`=1) → 0x01 (`tick` 0, `wrap` 0).
- Modulo up, `limit`=5, from `clr`:
  - `cnt` 0,1,2,3,4,5,0 with `wrap` only on the return to 0.
  - Next, hold `cnt`=5, set `limit`=3 → next `cnt`=0 with `wrap`.
- Modulo down, `limit`=4, load 0 → `cnt` 4 (`wrap`=1), then 3,2,1,0,4.
- One-shot down:
  - Load 3, `mode`=10, `dir`=1 → `cnt` 2,1,0 with `done`=1 on the 0 edge.
  - Hold `en` for 5 cycles → `cnt`=0 and `done`=1 throughout.
  - Load 7 → `done`=0, `cnt`=7.
- Priority: `clr`=1 and `load`=1 with `load_val`=0x40 → `cnt`=0. With `load`=1, `en`=0, `load_val`=0x40 → `cnt`=0x40, `tick`=0.
- Reset mid-count: free-run up from 0x20 to 0x25, assert `rst` between edges → `val`=0 and `tick`/`wrap`/`done`=0 immediately. Release → counting resumes from 0 on the first enabled edge.
